// File: rtl/wb_store_queue.sv
// wb_store_queue: in-order committed-store buffer that drains to the data-memory write port, with load-hazard and drain-handshake support
module wb_store_queue #(
  parameter int ADDRESS_WIDTH  = 64,
  parameter int REGISTER_WIDTH = 64,
  parameter int DEPTH          = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_store_valid,
  input  logic [ADDRESS_WIDTH-1:0]    in_store_addr,
  input  logic [REGISTER_WIDTH-1:0]   in_store_data,
  input  logic [1:0]                  in_store_size,
  output logic                        out_store_ready,
  output logic                        out_misaligned,
  input  logic [ADDRESS_WIDTH-1:0]    in_load_addr,
  output logic                        out_load_hazard,
  input  logic                        in_drain_req,
  output logic                        out_drained,
  output logic                        out_mem_req,
  output logic [ADDRESS_WIDTH-1:0]    out_mem_addr,
  output logic [REGISTER_WIDTH-1:0]   out_mem_data,
  output logic [7:0]                  out_mem_bytemask,
  input  logic                        in_mem_ack,
  output logic [$clog2(DEPTH):0]      out_count
);
  localparam int PW = $clog2(DEPTH);
  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;
  state_t state, state_next;
  logic [PW:0] rd_ptr, wr_ptr, count;
  logic [DEPTH-1:0] valid;
  logic [ADDRESS_WIDTH-1:0] e_addr [DEPTH];
  logic [REGISTER_WIDTH-1:0] e_data [DEPTH];
  logic [7:0] e_mask [DEPTH];
  logic empty, full, aligned, enq, deq, misaligned_q;
  logic [2:0] off, low_mask;
  logic [7:0] base_mask, lane_mask;
  logic [REGISTER_WIDTH-1:0] sized, lane_data;
  assign empty = rd_ptr == wr_ptr;
  assign full = (rd_ptr[PW] != wr_ptr[PW]) && (rd_ptr[PW-1:0] == wr_ptr[PW-1:0]);
  assign off = in_store_addr[2:0];
  assign low_mask = 3'((4'd1 << in_store_size) - 4'd1);
  assign aligned = (off & low_mask) == 3'd0;
  assign enq = in_store_valid && out_store_ready && aligned;
  assign deq = out_mem_req && in_mem_ack;
  // Lane placement is resolved at enqueue so the head only needs a straight read
  assign base_mask = in_store_size == 2'd3 ? 8'hFF : in_store_size == 2'd2 ? 8'h0F :
                     in_store_size == 2'd1 ? 8'h03 : 8'h01;
  assign lane_mask = base_mask << off;
  assign sized = in_store_size == 2'd3 ? in_store_data :
                 in_store_size == 2'd2 ? REGISTER_WIDTH'(in_store_data[31:0]) :
                 in_store_size == 2'd1 ? REGISTER_WIDTH'(in_store_data[15:0]) :
                 REGISTER_WIDTH'(in_store_data[7:0]);
  assign lane_data = sized << {off, 3'b000};
  assign out_mem_req = !empty;
  assign out_mem_addr = out_mem_req ? e_addr[rd_ptr[PW-1:0]] : '0;
  assign out_mem_data = out_mem_req ? e_data[rd_ptr[PW-1:0]] : '0;
  assign out_mem_bytemask = out_mem_req ? e_mask[rd_ptr[PW-1:0]] : '0;
  assign out_misaligned = misaligned_q;
  assign out_count = count;
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      valid <= '0;
      misaligned_q <= 1'b0;
    end else begin
      if (enq) valid[wr_ptr[PW-1:0]] <= 1'b1;
      if (deq) valid[rd_ptr[PW-1:0]] <= 1'b0;
      wr_ptr <= wr_ptr + (PW+1)'(enq);
      rd_ptr <= rd_ptr + (PW+1)'(deq);
      count <= count + (PW+1)'(enq) - (PW+1)'(deq);
      misaligned_q <= in_store_valid && out_store_ready && !aligned;
    end
  end
  always_ff @(posedge clk) begin
    if (enq) begin
      e_addr[wr_ptr[PW-1:0]] <= {in_store_addr[ADDRESS_WIDTH-1:3], 3'b000};
      e_data[wr_ptr[PW-1:0]] <= lane_data;
      e_mask[wr_ptr[PW-1:0]] <= lane_mask;
    end
  end
  always_comb begin
    out_load_hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      out_load_hazard |= valid[i] && e_addr[i] == {in_load_addr[ADDRESS_WIDTH-1:3], 3'b000};
  end
  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else state <= state_next;
  end
  always_comb begin
    state_next = state == RUN   ? (in_drain_req ? DRAIN : RUN) :
                 state == DRAIN ? (count == '0 ? DONE : DRAIN) : RUN;
  end
  always_comb begin
    out_store_ready = !reset && !full && state == RUN;
    out_drained = state == DONE;
  end
endmodule

// File: tb/tb_wb_store_queue.sv
// tb_wb_store_queue: directed vectors with hand-computed expectations for wb_store_queue
module tb_wb_store_queue;
  logic clk = 0, reset = 1;
  logic in_store_valid = 0, in_drain_req = 0, in_mem_ack = 0;
  logic [63:0] in_store_addr = 0, in_store_data = 0, in_load_addr = 0;
  logic [1:0] in_store_size = 0;
  logic out_store_ready, out_misaligned, out_load_hazard, out_drained, out_mem_req;
  logic [63:0] out_mem_addr, out_mem_data;
  logic [7:0] out_mem_bytemask;
  logic [2:0] out_count;
  int errors = 0, checks = 0;
  wb_store_queue dut (
    .clk(clk), .reset(reset), .in_store_valid(in_store_valid), .in_store_addr(in_store_addr),
    .in_store_data(in_store_data), .in_store_size(in_store_size), .out_store_ready(out_store_ready),
    .out_misaligned(out_misaligned), .in_load_addr(in_load_addr), .out_load_hazard(out_load_hazard),
    .in_drain_req(in_drain_req), .out_drained(out_drained), .out_mem_req(out_mem_req),
    .out_mem_addr(out_mem_addr), .out_mem_data(out_mem_data), .out_mem_bytemask(out_mem_bytemask),
    .in_mem_ack(in_mem_ack), .out_count(out_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [63:0] a, input logic [63:0] d, input logic [1:0] s);
    in_store_valid = 1; in_store_addr = a; in_store_data = d; in_store_size = s;
    tick;
    in_store_valid = 0;
  endtask
  initial begin
    tick; tick;
    chk("rst_count", out_count, 0);
    chk("rst_req", out_mem_req, 0);
    chk("rst_ready", out_store_ready, 0);
    reset = 0; #1;
    chk("ready_after_rst", out_store_ready, 1);
    // 1: four doublewords, then drain in order
    for (int i = 0; i < 4; i++) push(64'h1000 + 64'(8*i), 64'h1111_0000 + 64'(i), 2'd3);
    chk("t1_count", out_count, 4);
    chk("t1_ready", out_store_ready, 0);
    chk("t1_req", out_mem_req, 1);
    chk("t1_addr", out_mem_addr, 64'h1000);
    chk("t1_mask", out_mem_bytemask, 8'hFF);
    chk("t1_data", out_mem_data, 64'h1111_0000);
    in_mem_ack = 1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("t1_order", out_mem_addr, 64'h1000 + 64'(8*i));
      tick;
    end
    in_mem_ack = 0; #1;
    chk("t1_empty_count", out_count, 0);
    chk("t1_empty_req", out_mem_req, 0);
    // 2: byte lane placement and misaligned rejection
    push(64'h2005, 64'h12AB, 2'd0);
    chk("t2_addr", out_mem_addr, 64'h2000);
    chk("t2_mask", out_mem_bytemask, 8'h20);
    chk("t2_data", out_mem_data, 64'h0000AB0000000000);
    in_store_valid = 1; in_store_addr = 64'h2003; in_store_size = 2'd1; #1;
    chk("t2_mis_early", out_misaligned, 0);
    tick; in_store_valid = 0;
    chk("t2_mis_pulse", out_misaligned, 1);
    chk("t2_mis_count", out_count, 1);
    tick;
    chk("t2_mis_clear", out_misaligned, 0);
    in_mem_ack = 1; tick; in_mem_ack = 0;
    chk("t2_drained", out_count, 0);
    // 3: full queue with same-cycle ack still refuses
    for (int i = 0; i < 4; i++) push(64'h4000 + 64'(8*i), 64'(i), 2'd3);
    in_store_valid = 1; in_store_addr = 64'h4020; in_store_size = 2'd3; in_mem_ack = 1; #1;
    chk("t3_full_ready", out_store_ready, 0);
    tick; in_mem_ack = 0; #1;
    chk("t3_count3", out_count, 3);
    chk("t3_ready_again", out_store_ready, 1);
    tick; in_store_valid = 0;
    chk("t3_count4", out_count, 4);
    in_mem_ack = 1;
    repeat (4) tick;
    in_mem_ack = 0;
    chk("t3_empty", out_count, 0);
    // 4: load hazard by 8-byte line
    in_store_valid = 1; in_store_addr = 64'h3004; in_store_data = 64'hDEADBEEF; in_store_size = 2'd2;
    in_load_addr = 64'h3000; #1;
    chk("t4_not_yet", out_load_hazard, 0);
    tick; in_store_valid = 0;
    chk("t4_hit", out_load_hazard, 1);
    chk("t4_mask", out_mem_bytemask, 8'hF0);
    chk("t4_data", out_mem_data, 64'hDEADBEEF_00000000);
    in_load_addr = 64'h3008; #1;
    chk("t4_miss", out_load_hazard, 0);
    in_load_addr = 64'h3000; in_mem_ack = 1; tick; in_mem_ack = 0; #1;
    chk("t4_after_ack", out_load_hazard, 0);
    // 5: drain sequence
    push(64'h5000, 64'h1, 2'd3);
    push(64'h5008, 64'h2, 2'd3);
    in_drain_req = 1; in_mem_ack = 1; #1;
    chk("t5_ready_run", out_store_ready, 1);
    tick; in_drain_req = 0;
    chk("t5_ready_drain", out_store_ready, 0);
    chk("t5_count1", out_count, 1);
    chk("t5_no_pulse1", out_drained, 0);
    tick;
    chk("t5_count0", out_count, 0);
    chk("t5_no_pulse2", out_drained, 0);
    tick;
    chk("t5_pulse", out_drained, 1);
    chk("t5_ready_done", out_store_ready, 0);
    tick; in_mem_ack = 0;
    chk("t5_pulse_end", out_drained, 0);
    chk("t5_ready_back", out_store_ready, 1);
    in_drain_req = 1; tick; in_drain_req = 0;
    chk("t5e_wait", out_drained, 0);
    tick;
    chk("t5e_pulse", out_drained, 1);
    tick;
    chk("t5e_end", out_drained, 0);
    // 6: reset mid-operation discards entries and ignores ack
    for (int i = 0; i < 3; i++) push(64'h6000 + 64'(8*i), 64'(i), 2'd3);
    chk("t6_count3", out_count, 3);
    reset = 1; in_mem_ack = 1; tick;
    chk("t6_rst_count", out_count, 0);
    chk("t6_rst_req", out_mem_req, 0);
    reset = 0; in_mem_ack = 0; #1;
    chk("t6_ready", out_store_ready, 1);
    push(64'h7000, 64'h55, 2'd3);
    chk("t6_fresh_addr", out_mem_addr, 64'h7000);
    chk("t6_fresh_count", out_count, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
